// File: rtl/score_ctrl.sv
// score_ctrl: round/score sequencer between the ball miss detector and the ball motion stage.
// Turns miss levels into single scoring events and runs serve -> play -> point -> over.
module score_ctrl #(
  parameter logic [3:0] WIN_SCORE   = 4'd5,
  parameter logic [7:0] PAUSE_TICKS = 8'd3,
  parameter logic [7:0] SERVE_TICKS = 8'd2
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic       tick,
  input  logic       start,
  input  logic       miss1,
  input  logic       miss2,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [2:0] state,
  output logic       play_en,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  // Last tick index of each timed phase; a zero count behaves as one tick.
  localparam logic [7:0] SERVE_LAST = (SERVE_TICKS == 8'd0) ? 8'd0 : 8'(SERVE_TICKS - 8'd1);
  localparam logic [7:0] PAUSE_LAST = (PAUSE_TICKS == 8'd0) ? 8'd0 : 8'(PAUSE_TICKS - 8'd1);

  state_e      state_q, state_d;
  logic [3:0]  score1_q, score1_d;
  logic [3:0]  score2_q, score2_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        miss1_q, miss2_q;
  logic        serve_dir_q, serve_dir_d;
  logic [1:0]  winner_q, winner_d;
  logic        play_en_q, play_en_d;
  logic        ball_reset_q, ball_reset_d;
  logic        game_over_q, game_over_d;
  logic        ev1, ev2;

  always_comb begin
    ev1          = miss1 & ~miss1_q;
    ev2          = miss2 & ~miss2_q;
    state_d      = state_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    cnt_d        = cnt_q;
    serve_dir_d  = serve_dir_q;
    winner_d     = winner_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SERVE;
          cnt_d   = 8'd0;
        end
      end
      S_SERVE: begin
        if (tick) begin
          if (cnt_q == SERVE_LAST) begin
            state_d = S_PLAY;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = 8'(cnt_q + 8'd1);
          end
        end
      end
      S_PLAY: begin
        // Simultaneous misses on both sides are treated as no event.
        if (ev1 ^ ev2) begin
          if (ev1) begin
            score2_d    = 4'(score2_q + 4'd1);
            serve_dir_d = 1'b0;
          end else begin
            score1_d    = 4'(score1_q + 4'd1);
            serve_dir_d = 1'b1;
          end
          if ((score1_d == WIN_SCORE) || (score2_d == WIN_SCORE)) begin
            state_d  = S_OVER;
            winner_d = ev1 ? 2'b10 : 2'b01;
          end else begin
            state_d = S_POINT;
            cnt_d   = 8'd0;
          end
        end
      end
      S_POINT: begin
        if (tick) begin
          if (cnt_q == PAUSE_LAST) begin
            state_d = S_SERVE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = 8'(cnt_q + 8'd1);
          end
        end
      end
      S_OVER: begin
        if (start) begin
          state_d  = S_SERVE;
          score1_d = 4'd0;
          score2_d = 4'd0;
          winner_d = 2'b00;
          cnt_d    = 8'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Output flags follow the next state so they line up with the registered state.
    play_en_d    = (state_d == S_PLAY);
    ball_reset_d = (state_d == S_IDLE) || (state_d == S_SERVE) || (state_d == S_OVER);
    game_over_d  = (state_d == S_OVER);
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      score1_q     <= 4'd0;
      score2_q     <= 4'd0;
      cnt_q        <= 8'd0;
      miss1_q      <= 1'b0;
      miss2_q      <= 1'b0;
      serve_dir_q  <= 1'b1;
      winner_q     <= 2'b00;
      play_en_q    <= 1'b0;
      ball_reset_q <= 1'b1;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      cnt_q        <= cnt_d;
      miss1_q      <= miss1;
      miss2_q      <= miss2;
      serve_dir_q  <= serve_dir_d;
      winner_q     <= winner_d;
      play_en_q    <= play_en_d;
      ball_reset_q <= ball_reset_d;
      game_over_q  <= game_over_d;
    end
  end

  assign state      = state_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign play_en    = play_en_q;
  assign ball_reset = ball_reset_q;
  assign serve_dir  = serve_dir_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_score_ctrl.sv
// Bench for score_ctrl: directed vector table, hand-written game sequences,
// and random stimulus checked against a behavioural model of the game rules.
module tb_score_ctrl;

  localparam int WIN_I   = 5;
  localparam int PAUSE_I = 3;
  localparam int SERVE_I = 2;
  localparam int PAUSE_LEN = (PAUSE_I == 0) ? 1 : PAUSE_I;
  localparam int SERVE_LEN = (SERVE_I == 0) ? 1 : SERVE_I;

  logic       clk = 1'b0;
  logic       rst, tick, start, miss1, miss2;
  logic [3:0] score1, score2;
  logic [2:0] state;
  logic       play_en, ball_reset, serve_dir, game_over;
  logic [1:0] winner;

  score_ctrl #(
    .WIN_SCORE  (4'(WIN_I)),
    .PAUSE_TICKS(8'(PAUSE_I)),
    .SERVE_TICKS(8'(SERVE_I))
  ) dut (
    .CLOCK_50  (clk),
    .Reset     (rst),
    .tick      (tick),
    .start     (start),
    .miss1     (miss1),
    .miss2     (miss2),
    .score1    (score1),
    .score2    (score2),
    .state     (state),
    .play_en   (play_en),
    .ball_reset(ball_reset),
    .serve_dir (serve_dir),
    .game_over (game_over),
    .winner    (winner)
  );

  always #5 clk = ~clk;

  // Inputs packed as {rst, tick, start, miss1, miss2}; flags as {play_en, ball_reset, serve_dir, game_over}.
  typedef struct {
    logic [4:0] in;
    logic [2:0] st;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] fl;
    logic [1:0] win;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: game phase, scores and ticks elapsed in the current timed phase.
  int m_state, m_s1, m_s2, m_dir, m_win, m_elapsed, m_pm1, m_pm2;

  task automatic model_update(input logic [4:0] in);
    logic r, t, s, a, b, e1, e2;
    {r, t, s, a, b} = in;
    if (r) begin
      m_state = 0; m_s1 = 0; m_s2 = 0; m_dir = 1; m_win = 0;
      m_elapsed = 0; m_pm1 = 0; m_pm2 = 0;
      return;
    end
    e1 = a && (m_pm1 == 0);
    e2 = b && (m_pm2 == 0);
    m_pm1 = int'(a);
    m_pm2 = int'(b);
    case (m_state)
      0: if (s) begin m_state = 1; m_elapsed = 0; end
      1: if (t) begin
           m_elapsed++;
           if (m_elapsed >= SERVE_LEN) begin m_state = 2; m_elapsed = 0; end
         end
      2: if (e1 != e2) begin
           if (e1) begin m_s2++; m_dir = 0; end
           else begin m_s1++; m_dir = 1; end
           if (m_s1 == WIN_I || m_s2 == WIN_I) begin
             m_state = 4;
             m_win   = (m_s1 == WIN_I) ? 1 : 2;
           end else begin
             m_state = 3; m_elapsed = 0;
           end
         end
      3: if (t) begin
           m_elapsed++;
           if (m_elapsed >= PAUSE_LEN) begin m_state = 1; m_elapsed = 0; end
         end
      4: if (s) begin m_s1 = 0; m_s2 = 0; m_win = 0; m_state = 1; m_elapsed = 0; end
      default: m_state = 0;
    endcase
  endtask

  function automatic logic [16:0] model_pack();
    logic pe, br, go;
    pe = (m_state == 2);
    br = (m_state == 0) || (m_state == 1) || (m_state == 4);
    go = (m_state == 4);
    return {3'(m_state), 4'(m_s1), 4'(m_s2), pe, br, 1'(m_dir), go, 2'(m_win)};
  endfunction

  function automatic logic [16:0] dut_pack();
    return {state, score1, score2, play_en, ball_reset, serve_dir, game_over, winner};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs, take one clock edge, advance the model, sample 1 time unit later.
  task automatic step(input logic [4:0] in);
    {rst, tick, start, miss1, miss2} = in;
    @(posedge clk);
    model_update(in);
    #1;
  endtask

  task automatic add(input logic [4:0] in, input logic [2:0] st, input logic [3:0] s1,
                     input logic [3:0] s2, input logic [3:0] fl, input logic [1:0] win);
    vec_t v;
    v.in = in; v.st = st; v.s1 = s1; v.s2 = s2; v.fl = fl; v.win = win;
    tbl.push_back(v);
  endtask

  logic [4:0] rin;
  logic       lv1, lv2;

  initial begin
    {rst, tick, start, miss1, miss2} = 5'b0;

    // Reset, misses ignored in IDLE/SERVE, serve timing, held miss, point pause, double miss.
    add(5'b10000, 3'd0, 4'd0, 4'd0, 4'b0110, 2'd0);
    add(5'b10000, 3'd0, 4'd0, 4'd0, 4'b0110, 2'd0);
    add(5'b00010, 3'd0, 4'd0, 4'd0, 4'b0110, 2'd0);
    add(5'b00100, 3'd1, 4'd0, 4'd0, 4'b0110, 2'd0);
    add(5'b01001, 3'd1, 4'd0, 4'd0, 4'b0110, 2'd0);
    add(5'b00010, 3'd1, 4'd0, 4'd0, 4'b0110, 2'd0);
    add(5'b01000, 3'd2, 4'd0, 4'd0, 4'b1010, 2'd0);
    add(5'b00010, 3'd3, 4'd0, 4'd1, 4'b0000, 2'd0);
    for (int i = 0; i < 4; i++) add(5'b00010, 3'd3, 4'd0, 4'd1, 4'b0000, 2'd0);
    add(5'b00000, 3'd3, 4'd0, 4'd1, 4'b0000, 2'd0);
    add(5'b01000, 3'd3, 4'd0, 4'd1, 4'b0000, 2'd0);
    add(5'b01000, 3'd3, 4'd0, 4'd1, 4'b0000, 2'd0);
    add(5'b01000, 3'd1, 4'd0, 4'd1, 4'b0100, 2'd0);
    add(5'b01100, 3'd1, 4'd0, 4'd1, 4'b0100, 2'd0);
    add(5'b01000, 3'd2, 4'd0, 4'd1, 4'b1000, 2'd0);
    add(5'b00011, 3'd2, 4'd0, 4'd1, 4'b1000, 2'd0);
    add(5'b00011, 3'd2, 4'd0, 4'd1, 4'b1000, 2'd0);
    add(5'b00000, 3'd2, 4'd0, 4'd1, 4'b1000, 2'd0);

    foreach (tbl[i]) begin
      step(tbl[i].in);
      chk($sformatf("vec[%0d]", i), 32'(dut_pack()),
          32'({tbl[i].st, tbl[i].s1, tbl[i].s2, tbl[i].fl, tbl[i].win}));
    end

    // Player 2 misses five times across rounds: player 1 wins, then restart.
    step(5'b10000);
    step(5'b00100);
    for (int r = 0; r < 5; r++) begin
      step(5'b01000);
      step(5'b01000);
      chk("round_play", 32'(state), 32'd2);
      step(5'b00001);
      step(5'b00000);
      chk("round_score1", 32'(score1), 32'(r + 1));
      if (r < 4) begin
        chk("round_point", 32'(state), 32'd3);
        for (int k = 0; k < 3; k++) step(5'b01000);
        chk("round_reserve", 32'(state), 32'd1);
      end
    end
    chk("over_state", 32'(state), 32'd4);
    chk("over_flags", 32'({game_over, winner, play_en, ball_reset}), 32'b10101);
    step(5'b00000);
    chk("over_hold", 32'({state, score1, score2}), 32'({3'd4, 4'd5, 4'd0}));
    step(5'b00100);
    chk("restart", 32'({state, score1, score2, winner, game_over, serve_dir}),
        32'({3'd1, 4'd0, 4'd0, 2'd0, 1'b0, 1'b1}));

    // Reset while in POINT with score1 = 3.
    step(5'b10000);
    step(5'b00100);
    for (int r = 0; r < 3; r++) begin
      step(5'b01000);
      step(5'b01000);
      step(5'b00001);
      step(5'b00000);
      if (r < 2) for (int k = 0; k < 3; k++) step(5'b01000);
    end
    chk("pre_reset", 32'({state, score1}), 32'({3'd3, 4'd3}));
    step(5'b10000);
    chk("mid_reset", 32'(dut_pack()), 32'({3'd0, 4'd0, 4'd0, 4'b0110, 2'd0}));

    // Random play against the model.
    lv1 = 1'b0;
    lv2 = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) lv1 = ~lv1;
      if ($urandom_range(0, 5) == 0) lv2 = ~lv2;
      rin[4] = ($urandom_range(0, 299) == 0);
      rin[3] = ($urandom_range(0, 1) == 0);
      rin[2] = ($urandom_range(0, 9) == 0);
      rin[1] = lv1;
      rin[0] = lv2;
      step(rin);
      chk($sformatf("rand[%0d]", c), 32'(dut_pack()), 32'(model_pack()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
